// File: rtl/cache_level_pkg.sv
// Shared types, policy encodings and width helpers for the cache_level tag store.
package cache_level_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        UPDATE,
        RESP
    } state_e;

    localparam logic POL_WT   = 1'b0;
    localparam logic POL_WB   = 1'b1;
    localparam logic POL_FIFO = 1'b0;
    localparam logic POL_LRU  = 1'b1;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    // Index/way widths never shrink below one bit so vectors stay legal.
    function automatic int width_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/cache_level_if.sv
// Request/response/statistics bundle between a cache_level and its controller.
interface cache_level_if #(
    parameter int ADDR_W = 48,
    parameter int CNT_W  = 16
) ();

    logic              write_policy;
    logic              replace_policy;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;

    logic              resp_valid;
    logic              resp_hit;
    logic              resp_evict_valid;
    logic [ADDR_W-1:0] resp_evict_addr;
    logic              resp_evict_dirty;

    logic [CNT_W-1:0]  reads;
    logic [CNT_W-1:0]  writes;
    logic [CNT_W-1:0]  hits;
    logic [CNT_W-1:0]  misses;
    logic [CNT_W-1:0]  writebacks;

    modport master (
        output write_policy, replace_policy, req_valid, req_addr, req_write,
        input  req_ready, resp_valid, resp_hit, resp_evict_valid, resp_evict_addr,
        input  resp_evict_dirty, reads, writes, hits, misses, writebacks
    );

    modport slave (
        input  write_policy, replace_policy, req_valid, req_addr, req_write,
        output req_ready, resp_valid, resp_hit, resp_evict_valid, resp_evict_addr,
        output resp_evict_dirty, reads, writes, hits, misses, writebacks
    );

endinterface

// File: rtl/cache_level_repl.sv
// Replacement state per set: LRU age matrix and FIFO pointer, plus victim choice.
module cache_repl
    import cache_level_pkg::*;
#(
    parameter int ASSOC   = 4,
    parameter int NUMSETS = 8,
    localparam int WAY_W  = width_min1(ASSOC),
    localparam int IDX_W  = width_min1(NUMSETS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] idx,
    input  logic             policy,
    input  logic [ASSOC-1:0] valid_vec,
    input  logic             hit,
    input  logic [WAY_W-1:0] hit_way,
    input  logic             fill,
    output logic [WAY_W-1:0] victim_way
);

    logic [WAY_W-1:0] age_q      [NUMSETS][ASSOC];
    logic [WAY_W-1:0] age_d      [NUMSETS][ASSOC];
    logic [WAY_W-1:0] fifo_ptr_q [NUMSETS];
    logic [WAY_W-1:0] fifo_ptr_d [NUMSETS];

    logic             found_free;
    logic [WAY_W-1:0] oldest_age;
    logic [WAY_W-1:0] ref_age;

    // Victim: lowest free way first; a full set falls back to FIFO pointer or oldest age (lowest index on ties).
    always_comb begin
        victim_way = '0;
        found_free = 1'b0;
        oldest_age = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (!valid_vec[w] && !found_free) begin
                victim_way = WAY_W'(w);
                found_free = 1'b1;
            end
        end
        if (!found_free) begin
            if (policy == POL_FIFO) begin
                victim_way = fifo_ptr_q[idx];
            end else begin
                oldest_age = age_q[idx][0];
                for (int w = 1; w < ASSOC; w++) begin
                    if (age_q[idx][w] > oldest_age) begin
                        oldest_age = age_q[idx][w];
                        victim_way = WAY_W'(w);
                    end
                end
            end
        end
    end

    // Next replacement state; a fill into a free way ages every younger line as if the oldest slot was reused.
    always_comb begin
        age_d      = age_q;
        fifo_ptr_d = fifo_ptr_q;
        ref_age    = '0;
        if (hit && policy == POL_LRU) begin
            ref_age = age_q[idx][hit_way];
            for (int w = 0; w < ASSOC; w++) begin
                if (age_q[idx][w] < ref_age) begin
                    age_d[idx][w] = age_q[idx][w] + 1'b1;
                end
            end
            age_d[idx][hit_way] = '0;
        end
        if (fill) begin
            if (policy == POL_LRU) begin
                ref_age = (&valid_vec) ? age_q[idx][victim_way] : WAY_W'(ASSOC - 1);
                for (int w = 0; w < ASSOC; w++) begin
                    if (age_q[idx][w] < ref_age) begin
                        age_d[idx][w] = age_q[idx][w] + 1'b1;
                    end
                end
                age_d[idx][victim_way] = '0;
            end else if (&valid_vec) begin
                fifo_ptr_d[idx] = fifo_ptr_q[idx] + 1'b1;
            end
        end
    end

    // Replacement state registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUMSETS; s++) begin
                fifo_ptr_q[s] <= '0;
                for (int w = 0; w < ASSOC; w++) begin
                    age_q[s][w] <= '0;
                end
            end
        end else begin
            age_q      <= age_d;
            fifo_ptr_q <= fifo_ptr_d;
        end
    end

endmodule

// File: rtl/cache_level.sv
// Set-associative tag store with hit/miss, victim reporting and saturating statistics.
module cache_level
    import cache_level_pkg::*;
#(
    parameter int ADDR_W    = 48,
    parameter int BLOCKSIZE = 64,
    parameter int CACHESIZE = 2048,
    parameter int ASSOC     = 4,
    parameter int CNT_W     = 16
) (
    input  logic          clk,
    input  logic          reset,
    cache_level_if.slave  bus
);

    localparam int NUMSETS = CACHESIZE / (BLOCKSIZE * ASSOC);
    localparam int OFF_W   = width_min1(BLOCKSIZE);
    localparam int IDX_W   = width_min1(NUMSETS);
    localparam int TAG_W   = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W  = ADDR_W - OFF_W;
    localparam int WAY_W   = width_min1(ASSOC);
    localparam int SETS    = 1 << IDX_W;

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [7:0]        op_q, op_d;
    logic              wpol_q, wpol_d;
    logic              rpol_q, rpol_d;
    logic              hit_q, hit_d;
    logic [WAY_W-1:0]  hit_way_q, hit_way_d;
    logic [WAY_W-1:0]  victim_q, victim_d;

    logic              resp_valid_q, resp_valid_d;
    logic              resp_hit_q, resp_hit_d;
    logic              evict_valid_q, evict_valid_d;
    logic [ADDR_W-1:0] evict_addr_q, evict_addr_d;
    logic              evict_dirty_q, evict_dirty_d;

    logic [CNT_W-1:0]  reads_q, reads_d;
    logic [CNT_W-1:0]  writes_q, writes_d;
    logic [CNT_W-1:0]  hits_q, hits_d;
    logic [CNT_W-1:0]  misses_q, misses_d;
    logic [CNT_W-1:0]  writebacks_q, writebacks_d;

    logic [TAG_W-1:0]  tag_q   [SETS][ASSOC];
    logic [TAG_W-1:0]  tag_d   [SETS][ASSOC];
    logic [ASSOC-1:0]  valid_q [SETS];
    logic [ASSOC-1:0]  valid_d [SETS];
    logic [ASSOC-1:0]  dirty_q [SETS];
    logic [ASSOC-1:0]  dirty_d [SETS];

    logic [IDX_W-1:0]  set_idx;
    logic [TAG_W-1:0]  line_tag;
    logic              is_write;
    logic              lookup_hit;
    logic [WAY_W-1:0]  lookup_way;
    logic [WAY_W-1:0]  repl_victim;
    logic              victim_was_valid;
    logic              victim_was_dirty;

    assign set_idx  = line_q[IDX_W-1:0];
    assign line_tag = line_q[LINE_W-1:IDX_W];
    assign is_write = (op_q == OP_WRITE);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    cache_repl #(
        .ASSOC   (ASSOC),
        .NUMSETS (SETS)
    ) u_repl (
        .clk        (clk),
        .reset      (reset),
        .idx        (set_idx),
        .policy     (rpol_q),
        .valid_vec  (valid_q[set_idx]),
        .hit        ((state_q == UPDATE) && hit_q),
        .hit_way    (hit_way_q),
        .fill       ((state_q == UPDATE) && !hit_q),
        .victim_way (repl_victim)
    );

    // Parallel tag compare across all ways of the addressed set.
    always_comb begin
        lookup_hit = 1'b0;
        lookup_way = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (valid_q[set_idx][w] && (tag_q[set_idx][w] == line_tag) && !lookup_hit) begin
                lookup_hit = 1'b1;
                lookup_way = WAY_W'(w);
            end
        end
    end

    assign victim_was_valid = valid_q[set_idx][victim_q];
    assign victim_was_dirty = victim_was_valid && dirty_q[set_idx][victim_q];

    // FSM next state: accept, look up, commit tag/dirty/counters, then pulse the response.
    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        line_d        = line_q;
        op_d          = op_q;
        wpol_d        = wpol_q;
        rpol_d        = rpol_q;
        hit_d         = hit_q;
        hit_way_d     = hit_way_q;
        victim_d      = victim_q;
        resp_valid_d  = resp_valid_q;
        resp_hit_d    = resp_hit_q;
        evict_valid_d = evict_valid_q;
        evict_addr_d  = evict_addr_q;
        evict_dirty_d = evict_dirty_q;
        reads_d       = reads_q;
        writes_d      = writes_q;
        hits_d        = hits_q;
        misses_d      = misses_q;
        writebacks_d  = writebacks_q;
        tag_d         = tag_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    line_d      = bus.req_addr[ADDR_W-1:OFF_W];
                    op_d        = bus.req_write ? OP_WRITE : OP_READ;
                    wpol_d      = bus.write_policy;
                    rpol_d      = bus.replace_policy;
                    req_ready_d = 1'b0;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d     = lookup_hit;
                hit_way_d = lookup_way;
                victim_d  = repl_victim;
                state_d   = UPDATE;
            end
            UPDATE: begin
                if (is_write) begin
                    writes_d = sat_inc(writes_q);
                end else begin
                    reads_d = sat_inc(reads_q);
                end
                if (hit_q) begin
                    hits_d        = sat_inc(hits_q);
                    evict_valid_d = 1'b0;
                    evict_dirty_d = 1'b0;
                    evict_addr_d  = '0;
                    if (is_write && wpol_q == POL_WB) begin
                        dirty_d[set_idx][hit_way_q] = 1'b1;
                    end
                end else begin
                    misses_d      = sat_inc(misses_q);
                    evict_valid_d = victim_was_valid;
                    evict_dirty_d = victim_was_dirty;
                    evict_addr_d  = {tag_q[set_idx][victim_q], set_idx, {OFF_W{1'b0}}};
                    if (victim_was_dirty) begin
                        writebacks_d = sat_inc(writebacks_q);
                    end
                    tag_d[set_idx][victim_q]   = line_tag;
                    valid_d[set_idx][victim_q] = 1'b1;
                    dirty_d[set_idx][victim_q] = is_write && (wpol_q == POL_WB);
                end
                resp_hit_d   = hit_q;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, outputs, counters and tag arrays; reset clears everything but raises req_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            line_q        <= '0;
            op_q          <= OP_READ;
            wpol_q        <= POL_WT;
            rpol_q        <= POL_FIFO;
            hit_q         <= 1'b0;
            hit_way_q     <= '0;
            victim_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            evict_valid_q <= 1'b0;
            evict_addr_q  <= '0;
            evict_dirty_q <= 1'b0;
            reads_q       <= '0;
            writes_q      <= '0;
            hits_q        <= '0;
            misses_q      <= '0;
            writebacks_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < ASSOC; w++) begin
                    tag_q[s][w] <= '0;
                end
            end
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            line_q        <= line_d;
            op_q          <= op_d;
            wpol_q        <= wpol_d;
            rpol_q        <= rpol_d;
            hit_q         <= hit_d;
            hit_way_q     <= hit_way_d;
            victim_q      <= victim_d;
            resp_valid_q  <= resp_valid_d;
            resp_hit_q    <= resp_hit_d;
            evict_valid_q <= evict_valid_d;
            evict_addr_q  <= evict_addr_d;
            evict_dirty_q <= evict_dirty_d;
            reads_q       <= reads_d;
            writes_q      <= writes_d;
            hits_q        <= hits_d;
            misses_q      <= misses_d;
            writebacks_q  <= writebacks_d;
            tag_q         <= tag_d;
            valid_q       <= valid_d;
            dirty_q       <= dirty_d;
        end
    end

    assign bus.req_ready        = req_ready_q;
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_hit         = resp_hit_q;
    assign bus.resp_evict_valid = evict_valid_q;
    assign bus.resp_evict_addr  = evict_addr_q;
    assign bus.resp_evict_dirty = evict_dirty_q;
    assign bus.reads            = reads_q;
    assign bus.writes           = writes_q;
    assign bus.hits             = hits_q;
    assign bus.misses           = misses_q;
    assign bus.writebacks       = writebacks_q;

endmodule

// File: tb/tb_cache_level.sv
// Self-checking bench: two cache_level copies (16-bit and 4-bit counters) against a set/way scoreboard.
module tb_cache_level;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    cache_level_if #(.ADDR_W(48), .CNT_W(16)) bus ();
    cache_level_if #(.ADDR_W(48), .CNT_W(4))  bus_sat ();

    assign bus_sat.req_valid      = bus.req_valid;
    assign bus_sat.req_addr       = bus.req_addr;
    assign bus_sat.req_write      = bus.req_write;
    assign bus_sat.write_policy   = bus.write_policy;
    assign bus_sat.replace_policy = bus.replace_policy;

    cache_level #(.ADDR_W(48), .BLOCKSIZE(64), .CACHESIZE(2048), .ASSOC(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    cache_level #(.ADDR_W(48), .BLOCKSIZE(64), .CACHESIZE(2048), .ASSOC(4), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_sat)
    );

    int vec_count  = 0;
    int miscompare = 0;

    // Scoreboard: 8 sets x 4 ways, recency stamps for LRU, a FIFO pointer per set.
    logic [38:0] m_tag   [8][4];
    bit          m_valid [8][4];
    bit          m_dirty [8][4];
    int          m_stamp [8][4];
    int          m_fifo  [8];
    int          m_tick;
    int          n_reads, n_writes, n_hits, n_misses, n_wbs;

    bit          exp_hit, exp_ev_valid, exp_ev_dirty;
    logic [47:0] exp_ev_addr;

    bit          obs_hit, obs_ev_valid, obs_ev_dirty;
    logic [47:0] obs_ev_addr;

    logic [38:0] tag_pool [6];

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompare++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic int satv(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic modelClear();
        for (int s = 0; s < 8; s++) begin
            m_fifo[s] = 0;
            for (int w = 0; w < 4; w++) begin
                m_tag[s][w]   = '0;
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_stamp[s][w] = 0;
            end
        end
        m_tick = 0;
        n_reads = 0; n_writes = 0; n_hits = 0; n_misses = 0; n_wbs = 0;
    endtask

    task automatic modelAccess(input logic [47:0] addr, input bit wr, input bit wpol, input bit rpol);
        int set;
        int way;
        logic [38:0] tag;
        set = int'(addr[8:6]);
        tag = addr[47:9];
        way = -1;
        m_tick++;
        if (wr) n_writes++; else n_reads++;
        for (int w = 0; w < 4; w++)
            if (way < 0 && m_valid[set][w] && m_tag[set][w] == tag) way = w;
        exp_ev_valid = 0;
        exp_ev_dirty = 0;
        exp_ev_addr  = '0;
        if (way >= 0) begin
            exp_hit = 1;
            n_hits++;
            if (wr && wpol) m_dirty[set][way] = 1;
            m_stamp[set][way] = m_tick;
        end else begin
            exp_hit = 0;
            n_misses++;
            for (int w = 0; w < 4; w++)
                if (way < 0 && !m_valid[set][w]) way = w;
            if (way < 0) begin
                if (!rpol) begin
                    way = m_fifo[set];
                    m_fifo[set] = (m_fifo[set] + 1) % 4;
                end else begin
                    way = 0;
                    for (int w = 1; w < 4; w++)
                        if (m_stamp[set][w] < m_stamp[set][way]) way = w;
                end
                exp_ev_valid = 1;
                exp_ev_dirty = m_dirty[set][way];
                exp_ev_addr  = {m_tag[set][way], 3'(set), 6'd0};
                if (exp_ev_dirty) n_wbs++;
            end
            m_tag[set][way]   = tag;
            m_valid[set][way] = 1;
            m_dirty[set][way] = wr && wpol;
            m_stamp[set][way] = m_tick;
        end
    endtask

    task automatic doReset();
        bus.req_valid = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        modelClear();
        checkOutput("rst_ready", bus.req_ready, 1);
        checkOutput("rst_resp_valid", bus.resp_valid, 0);
        checkOutput("rst_reads", bus.reads, 0);
        checkOutput("rst_misses", bus.misses, 0);
        checkOutput("rst_evict_valid", bus.resp_evict_valid, 0);
        checkOutput("rst_sat_writebacks", bus_sat.writebacks, 0);
    endtask

    task automatic applyStimulus(input logic [47:0] addr, input bit wr, input bit wpol, input bit rpol);
        int  k;
        bit  ready_low;
        bit  got;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("req_ready_idle", bus.req_ready, 1);
        bus.req_addr       = addr;
        bus.req_write      = wr;
        bus.write_policy   = wpol;
        bus.replace_policy = rpol;
        bus.req_valid      = 1;
        @(posedge clk);
        #1 bus.req_valid = 0;
        ready_low = 1;
        got = 0;
        for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.req_ready) ready_low = 0;
            if (bus.resp_valid) begin
                got = 1;
                break;
            end
        end
        checkOutput("resp_latency", got ? k : 99, 3);
        checkOutput("busy_ready_low", ready_low, 1);
        obs_hit      = bus.resp_hit;
        obs_ev_valid = bus.resp_evict_valid;
        obs_ev_dirty = bus.resp_evict_dirty;
        obs_ev_addr  = bus.resp_evict_addr;
        modelAccess(addr, wr, wpol, rpol);
        checkOutput("resp_hit", obs_hit, exp_hit);
        checkOutput("evict_valid", obs_ev_valid, exp_ev_valid);
        checkOutput("evict_dirty", obs_ev_dirty, exp_ev_dirty);
        if (exp_ev_valid) checkOutput("evict_addr", obs_ev_addr, exp_ev_addr);
        checkOutput("reads", bus.reads, satv(n_reads, 65535));
        checkOutput("writes", bus.writes, satv(n_writes, 65535));
        checkOutput("hits", bus.hits, satv(n_hits, 65535));
        checkOutput("misses", bus.misses, satv(n_misses, 65535));
        checkOutput("writebacks", bus.writebacks, satv(n_wbs, 65535));
        checkOutput("sat_reads", bus_sat.reads, satv(n_reads, 15));
        checkOutput("sat_writes", bus_sat.writes, satv(n_writes, 15));
        checkOutput("sat_hits", bus_sat.hits, satv(n_hits, 15));
        checkOutput("sat_misses", bus_sat.misses, satv(n_misses, 15));
        checkOutput("sat_writebacks", bus_sat.writebacks, satv(n_wbs, 15));
        @(negedge clk);
        checkOutput("resp_pulse", bus.resp_valid, 0);
    endtask

    // Directed scenarios first, then randomized bursts with a fresh reset per replacement policy.
    initial begin
        logic [47:0] a;
        bit          rp;
        bus.req_valid      = 0;
        bus.req_addr       = '0;
        bus.req_write      = 0;
        bus.write_policy   = 0;
        bus.replace_policy = 0;
        tag_pool[0] = 39'd0;
        tag_pool[1] = 39'd1;
        tag_pool[2] = 39'd2;
        tag_pool[3] = 39'h7F_FFFF_FFFF;
        tag_pool[4] = 39'h40_0000_0000;
        tag_pool[5] = 39'h12_3456_789A;

        doReset();
        applyStimulus(48'h0000, 0, 0, 0);
        checkOutput("cold_hit", obs_hit, 0);
        checkOutput("cold_evict", obs_ev_valid, 0);
        applyStimulus(48'h0000, 0, 0, 0);
        checkOutput("warm_hit", obs_hit, 1);
        checkOutput("two_reads", bus.reads, 2);

        doReset();
        foreach (tag_pool[i]) if (i < 4) applyStimulus(48'(i) << 9, 0, 0, 0);
        applyStimulus(48'h0000, 0, 0, 0);
        applyStimulus(48'h0800, 0, 0, 0);
        checkOutput("fifo_evict_valid", obs_ev_valid, 1);
        checkOutput("fifo_evict_addr", obs_ev_addr, 48'h0000);

        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(48'(i) << 9, 0, 0, 1);
        applyStimulus(48'h0000, 0, 0, 1);
        applyStimulus(48'h0800, 0, 0, 1);
        checkOutput("lru_evict_addr", obs_ev_addr, 48'h0200);
        applyStimulus(48'h0000, 0, 0, 1);
        checkOutput("lru_keep_hit", obs_hit, 1);

        doReset();
        applyStimulus(48'h0000, 1, 1, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(48'(i) << 9, 0, 1, 0);
        checkOutput("wb_evict_dirty", obs_ev_dirty, 1);
        checkOutput("wb_evict_addr", obs_ev_addr, 48'h0000);
        checkOutput("wb_count", bus.writebacks, 1);

        doReset();
        applyStimulus(48'h0000, 1, 0, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(48'(i) << 9, 0, 0, 0);
        checkOutput("wt_evict_dirty", obs_ev_dirty, 0);
        checkOutput("wt_count", bus.writebacks, 0);
        checkOutput("wt_writes", bus.writes, 1);

        doReset();
        for (int i = 0; i < 20; i++) applyStimulus(48'h0040, 0, 0, 0);
        checkOutput("satur_reads", bus_sat.reads, 15);
        checkOutput("satur_hits", bus_sat.hits, 15);
        checkOutput("satur_misses", bus_sat.misses, 1);
        checkOutput("wide_reads", bus.reads, 20);

        doReset();
        applyStimulus(48'h0000, 0, 0, 0);
        applyStimulus(48'h0040, 0, 0, 0);
        bus.req_addr  = 48'h0000;
        bus.req_write = 0;
        bus.req_valid = 1;
        @(posedge clk);
        #1 bus.req_valid = 0;
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_ready", bus.req_ready, 1);
        checkOutput("midrst_resp_valid", bus.resp_valid, 0);
        checkOutput("midrst_reads", bus.reads, 0);
        checkOutput("midrst_hits", bus.hits, 0);
        reset = 0;
        modelClear();
        applyStimulus(48'h0000, 0, 0, 0);
        checkOutput("midrst_reread_miss", obs_hit, 0);

        for (int b = 0; b < 6; b++) begin
            doReset();
            rp = bit'($urandom_range(0, 1));
            for (int i = 0; i < 60; i++) begin
                a = {tag_pool[$urandom_range(0, 5)], 3'($urandom_range(0, 2)), 6'($urandom_range(0, 63))};
                applyStimulus(a, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), rp);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
        $finish;
    end

endmodule

// File: doc/cache_level.md
Name: cache_level

Overview:
- Parametrised single-level set-associative tag store with a valid/ready request handshake. Replaces the fixed-geometry two-level engine.
- Supports per-request FIFO or true-LRU replacement, and write-through or write-back with dirty tracking.
- Reports hit/miss and the victim line on every access, and keeps saturating statistics counters.
- Two instances (L1, L2) are chained by the next-level controller; this block holds tags only, no data.

Parameters:
- ADDR_W, 48, request address width.
- BLOCKSIZE, 64, line size in bytes (power of 2).
- CACHESIZE, 2048, capacity in bytes.
- ASSOC, 4, ways per set (power of 2, ≥2).
- CNT_W, 16, statistics counter width.
- Derived: NUMSETS=CACHESIZE/(BLOCKSIZE*ASSOC); OFF_W=log2(BLOCKSIZE); IDX_W=log2(NUMSETS) (min 1); TAG_W=ADDR_W-OFF_W-IDX_W.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- write_policy, in, 1, 0=write-through, 1=write-back; sampled at accept.
- replace_policy, in, 1, 0=FIFO, 1=LRU; sampled at accept.
- req_valid, in, 1, request present.
- req_ready, out, 1, block can accept.
- req_addr, in, ADDR_W, byte address.
- req_write, in, 1, 1=write op ('W'), 0=read.
- resp_valid, out, 1, one-cycle response pulse.
- resp_hit, out, 1, tag matched a valid way.
- resp_evict_valid, out, 1, a valid line was displaced.
- resp_evict_addr, out, ADDR_W, victim line address (offset bits zero).
- resp_evict_dirty, out, 1, victim was dirty (write-back needed).
- reads, writes, hits, misses, writebacks, out, CNT_W each, statistics.

Behaviour:
- Reset (sync, any state): FSM→IDLE; all valid/dirty/age/FIFO pointers cleared; all outputs 0 except req_ready=1; counters 0.
- Address split: tag=addr[ADDR_W-1:OFF_W+IDX_W], idx=addr[OFF_W+IDX_W-1:OFF_W].
- FSM states: IDLE, LOOKUP, UPDATE, RESP.
  - IDLE: req_ready=1. Accept on req_valid&&req_ready; latch addr, op and both policies; go to LOOKUP.
  - LOOKUP: compare all ways in parallel; latch hit and hit_way. On a miss, choose the victim: lowest-index invalid way if any; else FIFO pointer[idx] (FIFO) or the way with age==ASSOC-1 (LRU).
  - UPDATE: write tag/valid/dirty, update replacement state and counters.
  - RESP: resp_valid=1 for exactly one cycle; then go to IDLE.
- Latency: accept at cycle N gives resp_valid at N+3. req_ready=0 outside IDLE. Inputs are ignored while busy.
- Hit, LRU: hit way age←0; ways with age < old age increment. Hit, FIFO: no replacement-state change.
- Miss (fill):
  - Victim way gets the new tag, valid=1.
  - dirty = req_write && write_policy.
  - LRU: filled way age←0; all others with age < victim age increment.
  - FIFO: pointer[idx] increments mod ASSOC, only when the fill displaced a valid way.
- Write hit: WB sets dirty; WT leaves dirty at 0.
- Eviction: resp_evict_valid=1 only if the victim was valid. resp_evict_addr={victim_tag, idx, OFF_W'0}. resp_evict_dirty=victim dirty. writebacks increments when the victim was valid and dirty.
- Counters (update in UPDATE, saturate at all-ones, never wrap):
  - reads increments on read ops; writes increments on write ops.
  - hits or misses increments on every access.
- Policy change mid-run: existing age state stays valid and FIFO pointers persist. No flush.
- Response outputs hold their last values when resp_valid=0, except resp_valid itself.

Decomposition:
- cache_pkg holds:
  - state enum (IDLE/LOOKUP/UPDATE/RESP);
  - policy constants WT/WB and FIFO/LRU;
  - op code constant 8'h57;
  - clog2-based derived-width functions.
- Sub-module cache_repl(ASSOC, NUMSETS):
  - per-set age matrix and FIFO pointers;
  - inputs idx, hit, hit_way, fill, valid vector, policy;
  - output victim_way.
- Tag/valid/dirty arrays stay in cache_level.

Test Plan:
- Defaults (NUMSETS=8). Read 0x0000, then read 0x0000 again → first access resp_hit=0, evict_valid=0; second resp_hit=1; reads=2, hits=1, misses=1; resp_valid at N+3; req_ready=0 for 3 cycles.
- FIFO: read 0x0000, 0x0200, 0x0400, 0x0600 (set 0), re-read 0x0000, then read 0x0800 → evict_valid=1, evict_addr=0x0000.
- LRU: same sequence → evict_addr=0x0200; re-reading 0x0000 then gives hit=1.
- Write-back: write 0x0000 (WB), then read 0x0200, 0x0400, 0x0600, 0x0800 under FIFO → last response evict_dirty=1, evict_addr=0x0000, writebacks=1. Same sequence under WT → evict_dirty=0, writebacks=0, writes=1.
- Saturation (CNT_W=4): 20 reads to 0x0040 → reads=15, hits=15, misses=1.
- Assert reset during LOOKUP → next cycle req_ready=1, resp_valid=0, counters 0; prior lines miss on re-read.
